// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and default sizing for the register-file write-back queue.
// Holds the queue entry layout and the default DEPTH/AW/DW constants.
package regfile_wb_queue_pkg;

   localparam int WBQ_DEPTH = 4;
   localparam int WBQ_AW    = 4;
   localparam int WBQ_DW    = 16;

   typedef struct packed {
      logic [WBQ_AW-1:0] rd;
      logic [WBQ_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_fwd_match.sv
// wbq_fwd_match: searches the queued entries for one read address.
// Ports: flattened rd/data arrays, head, count, addr in; hit, data out.
module wbq_fwd_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 4,
   parameter int DW    = 16,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic [DEPTH*AW-1:0] rds,
   input  logic [DEPTH*DW-1:0] dats,
   input  logic [PW-1:0]       head,
   input  logic [CW-1:0]       count,
   input  logic [AW-1:0]       addr,
   output logic                hit,
   output logic [DW-1:0]       data
);

   logic [PW-1:0] idx;

   // Walk oldest to youngest; the last match seen is the youngest.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count && rds[idx*AW +: AW] == addr) begin
            hit  = 1'b1;
            data = dats[idx*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue merging ALU and load results into one regfile write port.
// Ports: clk, rst (async low), alu_*/mem_* handshakes, wb_hold, flush,
// Rd/RW/wr write port, Rs/Rt -> fwd1_*/fwd2_*, empty/count.
// Optional forwarding search enabled by defining WBQ_FWD_EN.
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_hold,
   input  logic          flush,
   output logic [AW-1:0] Rd,
   output logic [DW-1:0] RW,
   output logic          wr,
   input  logic [AW-1:0] Rs,
   input  logic [AW-1:0] Rt,
   output logic          fwd1_hit,
   output logic [DW-1:0] fwd1_data,
   output logic          fwd2_hit,
   output logic [DW-1:0] fwd2_data,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [AW-1:0] rd_q  [DEPTH];
   logic [DW-1:0] dat_q [DEPTH];
   logic [PW-1:0] head_q, tail_q, mem_idx;
   logic [CW-1:0] count_q, free;
   logic          alu_fire, mem_fire;
   logic [1:0]    n_in;

   assign free      = CW'(DEPTH) - count_q;
   assign empty     = (count_q == '0);
   assign count     = count_q;
   // Readies look only at registered occupancy, never a same-cycle pop.
   assign alu_ready = !flush && (free >= CW'(1));
   assign mem_ready = !flush &&
                      ((free >= CW'(2)) ||
                       (free == CW'(1) && !alu_valid));
   assign alu_fire  = alu_valid && alu_ready;
   assign mem_fire  = mem_valid && mem_ready;
   assign n_in      = {1'b0, alu_fire} + {1'b0, mem_fire};
   // ALU entry is older, so MEM lands one slot behind it.
   assign mem_idx   = tail_q + PW'(alu_fire);

   assign wr = !empty && !wb_hold && !flush;
   // Storage is not reset; gating keeps the port quiet when empty.
   assign Rd = empty ? '0 : rd_q[head_q];
   assign RW = empty ? '0 : dat_q[head_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PW'(wr);
         tail_q  <= tail_q + PW'(n_in);
         count_q <= count_q + CW'(n_in) - CW'(wr);
      end
   end

   always_ff @(posedge clk) begin
      if (alu_fire) begin
         rd_q[tail_q]  <= alu_rd;
         dat_q[tail_q] <= alu_data;
      end
      if (mem_fire) begin
         rd_q[mem_idx]  <= mem_rd;
         dat_q[mem_idx] <= mem_data;
      end
   end

`ifdef WBQ_FWD_EN
   logic [DEPTH*AW-1:0] rds;
   logic [DEPTH*DW-1:0] dats;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign rds[g*AW +: AW]  = rd_q[g];
      assign dats[g*DW +: DW] = dat_q[g];
   end

   wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
      .rds   (rds),
      .dats  (dats),
      .head  (head_q),
      .count (count_q),
      .addr  (Rs),
      .hit   (fwd1_hit),
      .data  (fwd1_data)
   );

   wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
      .rds   (rds),
      .dats  (dats),
      .head  (head_q),
      .count (count_q),
      .addr  (Rt),
      .hit   (fwd2_hit),
      .data  (fwd2_data)
   );
`else
   logic fwd_unused;
   assign fwd_unused = ^{Rs, Rt};
   assign fwd1_hit   = 1'b0;
   assign fwd1_data  = '0;
   assign fwd2_hit   = 1'b0;
   assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 4;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, wb_hold, flush;
   logic          alu_ready, mem_ready, wr, empty;
   logic [AW-1:0] alu_rd, mem_rd, Rd, Rs, Rt;
   logic [DW-1:0] alu_data, mem_data, RW;
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd1_data, fwd2_data;
   logic [2:0]    count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .wb_hold   (wb_hold),
      .flush     (flush),
      .Rd        (Rd),
      .RW        (RW),
      .wr        (wr),
      .Rs        (Rs),
      .Rt        (Rt),
      .fwd1_hit  (fwd1_hit),
      .fwd1_data (fwd1_data),
      .fwd2_hit  (fwd2_hit),
      .fwd2_data (fwd2_data),
      .empty     (empty),
      .count     (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0;
      alu_rd = '0; alu_data = '0;
      mem_rd = '0; mem_data = '0;
   endtask

   task automatic test_reset();
      rst = 0; wb_hold = 0; flush = 0; Rs = '0; Rt = '0;
      idle();
      #3;
      checks++;
      if ({empty, wr, Rd, RW, count, fwd1_hit, fwd2_hit} !==
          {1'b1, 1'b0, 4'h0, 16'h0, 3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: empty=%b wr=%b Rd=%h RW=%h cnt=%0d want 1 0 0 0 0",
                  empty, wr, Rd, RW, count);
      end
      tick();
      rst = 1;
      #1;
      checks++;
      if (alu_ready !== 1 || mem_ready !== 1) begin
         errors++;
         $display("FAIL reset_ready: alu=%b mem=%b want 1 1", alu_ready, mem_ready);
      end
   endtask

   task automatic test_single();
      alu_valid = 1; alu_rd = 4'd3; alu_data = 16'hA5A5;
      tick();
      idle();
      checks++;
      if (wr !== 1 || Rd !== 4'd3 || RW !== 16'hA5A5) begin
         errors++;
         $display("FAIL single_write: wr=%b Rd=%h RW=%h want 1 3 a5a5", wr, Rd, RW);
      end
      tick();
      checks++;
      if (empty !== 1 || wr !== 0) begin
         errors++;
         $display("FAIL single_drain: empty=%b wr=%b want 1 0", empty, wr);
      end
   endtask

   task automatic test_dual();
      alu_valid = 1; alu_rd = 4'd1; alu_data = 16'h0011;
      mem_valid = 1; mem_rd = 4'd2; mem_data = 16'h0022;
      tick();
      idle();
      checks++;
      if (wr !== 1 || Rd !== 4'd1 || RW !== 16'h0011 || count !== 3'd2) begin
         errors++;
         $display("FAIL dual_first: wr=%b Rd=%h RW=%h cnt=%0d want 1 1 0011 2",
                  wr, Rd, RW, count);
      end
      tick();
      checks++;
      if (wr !== 1 || Rd !== 4'd2 || RW !== 16'h0022) begin
         errors++;
         $display("FAIL dual_second: wr=%b Rd=%h RW=%h want 1 2 0022", wr, Rd, RW);
      end
      tick();
      checks++;
      if (empty !== 1) begin
         errors++;
         $display("FAIL dual_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_hold();
      logic [AW-1:0] exp_rd [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
      wb_hold = 1;
      for (int c = 0; c < 2; c++) begin
         alu_valid = 1; alu_rd = exp_rd[2*c]; alu_data = 16'(16'h100 + 2*c);
         mem_valid = 1; mem_rd = exp_rd[2*c+1]; mem_data = 16'(16'h101 + 2*c);
         tick();
      end
      idle();
      alu_valid = 1; mem_valid = 1;
      #1;
      checks++;
      if (count !== 3'd4 || alu_ready !== 0 || mem_ready !== 0 || wr !== 0) begin
         errors++;
         $display("FAIL hold_full: cnt=%0d ar=%b mr=%b wr=%b want 4 0 0 0",
                  count, alu_ready, mem_ready, wr);
      end
      idle();
      wb_hold = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (wr !== 1 || Rd !== exp_rd[k] || RW !== 16'(16'h100 + k)) begin
            errors++;
            $display("FAIL hold_drain%0d: wr=%b Rd=%h RW=%h want 1 %h %h",
                     k, wr, Rd, RW, exp_rd[k], 16'(16'h100 + k));
         end
         tick();
      end
      checks++;
      if (empty !== 1) begin
         errors++;
         $display("FAIL hold_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_fwd();
      logic          eh;
      logic [DW-1:0] ed;
      wb_hold = 1;
      alu_valid = 1; alu_rd = 4'd5; alu_data = 16'h0001;
      mem_valid = 1; mem_rd = 4'd5; mem_data = 16'h0002;
      tick();
      idle();
      Rs = 4'd5; Rt = 4'd7;
`ifdef WBQ_FWD_EN
      eh = 1; ed = 16'h0002;
`else
      eh = 0; ed = 16'h0000;
`endif
      #1;
      checks++;
      if (fwd1_hit !== eh || fwd1_data !== ed || fwd2_hit !== 0) begin
         errors++;
         $display("FAIL fwd_youngest: h1=%b d1=%h h2=%b want %b %h 0",
                  fwd1_hit, fwd1_data, fwd2_hit, eh, ed);
      end
      flush = 1;
      tick();
      flush = 0; wb_hold = 0;
   endtask

   task automatic test_flush();
      wb_hold = 1;
      alu_valid = 1; alu_rd = 4'd10; alu_data = 16'hDEAD;
      mem_valid = 1; mem_rd = 4'd11; mem_data = 16'hBEEF;
      tick();
      mem_valid = 0;
      tick();
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL flush_fill: cnt=%0d want 3", count);
      end
      flush = 1; wb_hold = 0;
      alu_valid = 1; alu_rd = 4'd12;
      #1;
      checks++;
      if (alu_ready !== 0 || mem_ready !== 0 || wr !== 0) begin
         errors++;
         $display("FAIL flush_gate: ar=%b mr=%b wr=%b want 0 0 0",
                  alu_ready, mem_ready, wr);
      end
      tick();
      flush = 0;
      idle();
      checks++;
      if (count !== 3'd0 || wr !== 0 || empty !== 1) begin
         errors++;
         $display("FAIL flush_clear: cnt=%0d wr=%b empty=%b want 0 0 1",
                  count, wr, empty);
      end
   endtask

   task automatic test_reset_mid();
      wb_hold = 1;
      alu_valid = 1; alu_rd = 4'd1; alu_data = 16'h1111;
      mem_valid = 1; mem_rd = 4'd2; mem_data = 16'h2222;
      tick();
      mem_valid = 0;
      tick();
      idle();
      wb_hold = 0;
      tick();
      #2;
      rst = 0;
      #1;
      checks++;
      if (wr !== 0 || empty !== 1 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset_async: wr=%b empty=%b cnt=%0d want 0 1 0",
                  wr, empty, count);
      end
      tick();
      rst = 1;
      alu_valid = 1; alu_rd = 4'hA; alu_data = 16'h0BEE;
      tick();
      idle();
      checks++;
      if (wr !== 1 || Rd !== 4'hA || RW !== 16'h0BEE || count !== 3'd1) begin
         errors++;
         $display("FAIL reset_restart: wr=%b Rd=%h RW=%h cnt=%0d want 1 a 0bee 1",
                  wr, Rd, RW, count);
      end
      tick();
   endtask

   task automatic test_random();
      logic [AW-1:0] q_rd [$];
      logic [DW-1:0] q_d  [$];
      logic          e_ar, e_mr, e_wr, e_h1, e_h2;
      logic [DW-1:0] e_d1, e_d2;
      int            fr;
      for (int n = 0; n < 400; n++) begin
         alu_valid = ($urandom_range(0, 9) < 6);
         mem_valid = ($urandom_range(0, 9) < 6);
         alu_rd = AW'($urandom); alu_data = DW'($urandom);
         mem_rd = AW'($urandom); mem_data = DW'($urandom);
         wb_hold = ($urandom_range(0, 9) < 3);
         flush = ($urandom_range(0, 39) == 0);
         Rs = AW'($urandom_range(0, 3)); Rt = AW'($urandom_range(0, 3));
         alu_rd[3:2] = 2'b00;
         mem_rd[3:2] = 2'b00;
         fr = DEPTH - q_rd.size();
         e_ar = !flush && fr >= 1;
         e_mr = !flush && (fr >= 2 || (fr == 1 && !alu_valid));
         e_wr = q_rd.size() > 0 && !wb_hold && !flush;
         e_h1 = 0; e_d1 = '0; e_h2 = 0; e_d2 = '0;
`ifdef WBQ_FWD_EN
         foreach (q_rd[i]) begin
            if (q_rd[i] == Rs) begin e_h1 = 1; e_d1 = q_d[i]; end
            if (q_rd[i] == Rt) begin e_h2 = 1; e_d2 = q_d[i]; end
         end
`endif
         #1;
         checks++;
         if (alu_ready !== e_ar || mem_ready !== e_mr || wr !== e_wr ||
             count !== 3'(q_rd.size()) || empty !== (q_rd.size() == 0)) begin
            errors++;
            $display("FAIL rnd_ctl%0d: ar=%b mr=%b wr=%b cnt=%0d want %b %b %b %0d",
                     n, alu_ready, mem_ready, wr, count, e_ar, e_mr, e_wr, q_rd.size());
         end
         if (e_wr) begin
            checks++;
            if (Rd !== q_rd[0] || RW !== q_d[0]) begin
               errors++;
               $display("FAIL rnd_head%0d: Rd=%h RW=%h want %h %h",
                        n, Rd, RW, q_rd[0], q_d[0]);
            end
         end
         checks++;
         if (fwd1_hit !== e_h1 || fwd1_data !== e_d1 ||
             fwd2_hit !== e_h2 || fwd2_data !== e_d2) begin
            errors++;
            $display("FAIL rnd_fwd%0d: %b %h %b %h want %b %h %b %h", n,
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, e_h1, e_d1, e_h2, e_d2);
         end
         @(posedge clk);
         if (flush) begin
            q_rd.delete(); q_d.delete();
         end else begin
            if (e_wr) begin
               void'(q_rd.pop_front()); void'(q_d.pop_front());
            end
            if (alu_valid && e_ar) begin
               q_rd.push_back(alu_rd); q_d.push_back(alu_data);
            end
            if (mem_valid && e_mr) begin
               q_rd.push_back(mem_rd); q_d.push_back(mem_data);
            end
         end
         #1;
      end
      idle();
      wb_hold = 0; flush = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_hold();
      test_fwd();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
